// File: rtl/sqcsa_pkg.sv
// sqcsa_pkg: shared FSM state encoding and default geometry for the sequential carry-select adder.
package sqcsa_pkg;
    localparam int DEF_DWIDTH = 16;
    localparam int DEF_SLICE  = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/csa_slice.sv
// csa_slice: combinational carry-select slice; both carry-in outcomes are summed in parallel and muxed.
module csa_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);
    logic [W:0] s0, s1;
    assign s0    = {1'b0, a} + {1'b0, b};
    assign s1    = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    assign sum   = c_in ? s1[W-1:0] : s0[W-1:0];
    assign c_out = c_in ? s1[W] : s0[W];
    // carry into the MSB recovered from the MSB sum bit
    assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
endmodule

// File: rtl/sqcsa_seq_ctrl.sv
// sqcsa_seq_ctrl: sequential adder processing one SLICE-bit carry-select slice per cycle with req/rsp handshakes.
// Defining SQCSA_SEQ_CTRL_OVF_EN adds the signed-overflow output rsp_ovf.
module sqcsa_seq_ctrl
    import sqcsa_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int SLICE  = DEF_SLICE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DWIDTH-1:0] req_a,
    input  logic [DWIDTH-1:0] req_b,
    input  logic              req_c_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_sum,
`ifdef SQCSA_SEQ_CTRL_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic              rsp_c_out,
    output logic              busy
);
    localparam int NSLICE = DWIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DWIDTH-1:0]   a_r, b_r, sum_r;
    logic                carry;
    logic [SLICE-1:0]    s_sum;
    logic                s_co, msb_c;

    csa_slice #(.W(SLICE)) u_slice (
        .a     (a_r[cnt*SLICE +: SLICE]),
        .b     (b_r[cnt*SLICE +: SLICE]),
        .c_in  (carry),
        .sum   (s_sum),
        .c_out (s_co),
        .c_msb (msb_c)
    );

    assign req_ready = state == IDLE;
    assign rsp_valid = state == DONE;
    assign busy      = state != IDLE;
    assign rsp_sum   = sum_r;
    assign rsp_c_out = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
        end else if (state == IDLE) begin
            if (req_valid) begin
                a_r   <= req_a;
                b_r   <= req_b;
                carry <= req_c_in;
                cnt   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            sum_r[cnt*SLICE +: SLICE] <= s_sum;
            carry <= s_co;
            cnt   <= (cnt == CW'(NSLICE-1)) ? cnt : cnt + CW'(1);
            state <= (cnt == CW'(NSLICE-1)) ? DONE : RUN;
        end else begin
            state <= rsp_ready ? IDLE : state;
        end
    end

`ifdef SQCSA_SEQ_CTRL_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_ovf <= 1'b0;
        else if (state == RUN && cnt == CW'(NSLICE-1))
            rsp_ovf <= msb_c ^ s_co;
    end
`else
    logic unused_ok;
    assign unused_ok = msb_c;
`endif
endmodule

// File: doc/sqcsa_seq_ctrl.md
SQCSA_SEQ_CTRL -- requirements
Module: sqcsa_seq_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, operand/result width; legal values are multiples of SLICE and at least SLICE.
REQ-002 SHALL have parameter SLICE, default 4, bits added per cycle by the carry-select slice.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have ports req_a, req_b  input  DWIDTH  operands.
REQ-008 SHALL have port req_c_in  input  1  initial carry.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_sum  output  DWIDTH  sum modulo 2^DWIDTH.
REQ-012 SHALL have port rsp_c_out  output  1  final carry out.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL define NSLICE = DWIDTH/SLICE and run an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive req_ready high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-016 SHALL, on accept, register req_a, req_b and req_c_in, clear the slice counter and enter RUN; later input changes SHALL be ignored.
REQ-017 SHALL, in RUN, add slice k (bits k*SLICE+SLICE-1 down to k*SLICE) in the k-th RUN cycle using the registered carry, write the slice sum into the result register and register the slice carry.
REQ-018 SHALL register the final slice at the NSLICE-th edge after the accepting edge, then enter DONE; rsp_valid therefore rises exactly NSLICE cycles after accept.
REQ-019 SHALL hold rsp_valid high, and keep rsp_sum and rsp_c_out stable, in DONE until rsp_ready is high; on that edge it SHALL return to IDLE.
REQ-020 SHALL NOT accept a new request in the response-handshake cycle; req_ready rises the cycle after it (no back-to-back overlap).
REQ-021 SHALL handle DWIDTH == SLICE (NSLICE = 1) with a 1-bit counter, giving 1-cycle latency.
REQ-022 SHALL size the slice counter as max(1, clog2(NSLICE)) bits; the counter SHALL NOT wrap within one operation.
REQ-023 SHALL keep rsp_sum showing the last completed result while in IDLE.

Reset
REQ-024 SHALL, when rst_n is low, immediately set the state to IDLE, rsp_valid=0, busy=0, rsp_sum=0, rsp_c_out=0, carry and counter to 0, and drive req_ready=1 after release.
REQ-025 SHALL discard any operation aborted by reset mid-RUN or mid-DONE; no response is issued for it.

Configuration
REQ-026 SHALL, with SQCSA_SEQ_CTRL_OVF_EN defined, add output rsp_ovf (1 bit) = carry into MSB XOR carry out of MSB, registered with the final slice, reset 0, and stable while rsp_valid is high.
REQ-027 SHALL, without SQCSA_SEQ_CTRL_OVF_EN, omit port rsp_ovf and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, RUN, DONE) and the default DWIDTH/SLICE constants in shared package sqcsa_pkg.
REQ-029 SHALL instantiate one combinational sub-module, csa_slice: a SLICE-bit carry-select slice computing carry-0 and carry-1 sums in parallel, muxed by carry in, producing sum, carry out and the MSB carry-in.

Verification
REQ-030 SHALL check: a=16'h00FF, b=16'h0001, c_in=0 -> rsp_sum=16'h0100, rsp_c_out=0, rsp_valid 4 cycles after accept.
REQ-031 SHALL check: a=16'hFFFF, b=16'h0000, c_in=1 -> rsp_sum=16'h0000, rsp_c_out=1 (carry through all slices).
REQ-032 SHALL check: rsp_ready held low 5 cycles in DONE -> rsp_valid stays 1, rsp_sum stable, req_ready 0; req_ready rises the cycle after the handshake.
REQ-033 SHALL check: rst_n pulsed low in the 2nd RUN cycle -> outputs reset immediately, no response; next request 16'h1234+16'h1111 -> 16'h2345.
REQ-034 SHALL check: req_a changed the cycle after accept -> result uses the original operand.
REQ-035 SHALL check, with OVF_EN: 16'h7FFF+16'h0001 -> ovf=1, c_out=0; 16'h8000+16'h8000 -> sum 0, c_out=1, ovf=1.
